// File: rtl/ahb_sink_pkg.sv
// Shared constants and types for the AHB-lite stream sink: bus encodings,
// register offsets, STATUS/CTRL bit positions and the data-phase state type.
package ahb_sink_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int STAT_EMPTY   = 16;
    localparam int STAT_FULL    = 17;
    localparam int STAT_ERR     = 18;
    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_ERR = 1;

    // Kind of data phase currently in progress on the slave port
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA_WAIT,
        ST_ERR1,
        ST_ERR2
    } dp_state_t;

endpackage

// File: rtl/sink_fifo.sv
// Show-ahead FIFO: head is always the oldest word; flush empties it in one edge
// and takes priority over a concurrent pop.
module sink_fifo #(
    parameter int W_DATA = 32,
    parameter int DEPTH  = 16,
    parameter int W_CNT  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [W_DATA-1:0] wdata,
    output logic [W_CNT-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic [W_DATA-1:0] head
);
    localparam int W_PTR = $clog2(DEPTH);

    logic [W_DATA-1:0] mem [DEPTH];
    logic [W_PTR-1:0]  wr_ptr;
    logic [W_PTR-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == W_CNT'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + W_PTR'(1);
            if (do_pop)  rd_ptr <= rd_ptr + W_PTR'(1);
            count <= count + W_CNT'(do_push) - W_CNT'(do_pop);
        end
    end

endmodule

// File: rtl/ahb_stream_sink.sv
// AHB-lite slave that pushes DATA writes into a FIFO drained on a valid/ready
// stream, stalling writes while full, with STATUS/CTRL registers.
module ahb_stream_sink
    import ahb_sink_pkg::*;
#(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int W_BURST = 3,
    parameter int DEPTH   = 16,
    parameter int W_CNT   = $clog2(DEPTH + 1)
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSEL,
    input  logic [W_ADDR-1:0]  HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [W_BURST-1:0] HBURST,
    input  logic [W_DATA-1:0]  HWDATA,
    input  logic               HREADY,
    output logic               out_HREADY,
    output logic [1:0]         out_HRESP,
    output logic [W_DATA-1:0]  out_HRDATA,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [W_DATA-1:0]  m_data,
    output logic [W_CNT-1:0]   fill_level
);
    dp_state_t         state;
    dp_state_t         state_nxt;
    dp_state_t         dec_state;
    logic              accept;
    logic              dp_valid;
    logic              dp_write;
    logic [1:0]        dp_off;
    logic              err_sticky;
    logic              push;
    logic              pop;
    logic              flush;
    logic              clr_err;
    logic              ctrl_wr;
    logic              rd_status;
    logic              fifo_full;
    logic              fifo_empty;
    logic [W_CNT-1:0]  count;
    logic [W_DATA-1:0] head;
    logic              unused_bits;

    function automatic logic [W_DATA-1:0] pack_status(input logic [W_CNT-1:0] cnt,
                                                      input logic emp, input logic ful,
                                                      input logic err);
        logic [W_DATA-1:0] s;
        s              = '0;
        s[W_CNT-1:0]   = cnt;
        s[STAT_EMPTY]  = emp;
        s[STAT_FULL]   = ful;
        s[STAT_ERR]    = err;
        return s;
    endfunction

    assign unused_bits = ^{HBURST, HADDR[W_ADDR-1:4], HADDR[1:0]};

    // Address phase: classify the transfer so its data phase starts in the right state
    always_comb begin
        accept    = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
        dec_state = ST_IDLE;
        if (accept) begin
            if ((HADDR[3:2] == OFF_RSVD) ||
                (HWRITE && HADDR[3:2] == OFF_DATA && HSIZE != HSIZE_WORD)) begin
                dec_state = ST_ERR1;
            end else if (HWRITE && HADDR[3:2] == OFF_DATA) begin
                dec_state = ST_DATA_WAIT;
            end
        end
    end

    // Data phase: full-FIFO stall decision uses only the registered count
    always_comb begin
        state_nxt  = dec_state;
        out_HREADY = 1'b1;
        out_HRESP  = HRESP_OKAY;
        push       = 1'b0;
        case (state)
            ST_DATA_WAIT: begin
                if (fifo_full) begin
                    out_HREADY = 1'b0;
                    state_nxt  = ST_DATA_WAIT;
                end else begin
                    push = 1'b1;
                end
            end
            ST_ERR1: begin
                out_HREADY = 1'b0;
                out_HRESP  = HRESP_ERROR;
                state_nxt  = ST_ERR2;
            end
            ST_ERR2: begin
                out_HRESP = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_off   <= OFF_DATA;
        end else begin
            state <= state_nxt;
            if (HREADY) begin
                dp_valid <= accept;
                dp_write <= HWRITE;
                dp_off   <= HADDR[3:2];
            end
        end
    end

    assign ctrl_wr   = (state == ST_IDLE) & dp_valid & dp_write & (dp_off == OFF_CTRL);
    assign rd_status = (state == ST_IDLE) & dp_valid & ~dp_write & (dp_off == OFF_STATUS);
    assign flush     = ctrl_wr & HWDATA[CTRL_FLUSH];
    assign clr_err   = ctrl_wr & HWDATA[CTRL_CLR_ERR];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err_sticky <= 1'b0;
        end else if (state == ST_ERR2) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

    assign out_HRDATA = rd_status ? pack_status(count, fifo_empty, fifo_full, err_sticky) : '0;
    assign m_valid    = ~fifo_empty;
    assign m_data     = head;
    assign pop        = m_valid & m_ready;
    assign fill_level = count;

    sink_fifo #(
        .W_DATA (W_DATA),
        .DEPTH  (DEPTH),
        .W_CNT  (W_CNT)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (HWDATA),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

endmodule

// File: tb/tb_ahb_stream_sink.sv
// Scoreboard bench for ahb_stream_sink: pushed words are queued when driven
// and compared against m_data on every stream handshake.
module tb_ahb_stream_sink;
    import ahb_sink_pkg::*;

    localparam int W_ADDR  = 32;
    localparam int W_DATA  = 32;
    localparam int W_BURST = 3;
    localparam int DEPTH   = 16;
    localparam int W_CNT   = $clog2(DEPTH + 1);

    logic               HCLK = 1'b0;
    logic               HRESET;
    logic               HSEL;
    logic [W_ADDR-1:0]  HADDR;
    logic [1:0]         HTRANS;
    logic               HWRITE;
    logic [2:0]         HSIZE;
    logic [W_BURST-1:0] HBURST;
    logic [W_DATA-1:0]  HWDATA;
    logic               out_HREADY;
    logic [1:0]         out_HRESP;
    logic [W_DATA-1:0]  out_HRDATA;
    logic               m_valid;
    logic               m_ready;
    logic [W_DATA-1:0]  m_data;
    logic [W_CNT-1:0]   fill_level;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic        dp_flush = 1'b0;

    always #5 HCLK = ~HCLK;

    ahb_stream_sink #(
        .W_ADDR (W_ADDR), .W_DATA (W_DATA), .W_BURST (W_BURST), .DEPTH (DEPTH), .W_CNT (W_CNT)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HWDATA     (HWDATA),
        .HREADY     (out_HREADY),
        .out_HREADY (out_HREADY),
        .out_HRESP  (out_HRESP),
        .out_HRDATA (out_HRDATA),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .fill_level (fill_level)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Consumer side: every handshake must present the oldest outstanding word
    always @(negedge HCLK) begin
        if (!HRESET) begin
            if (dp_flush) begin
                exp_q.delete();
            end else if (m_valid && m_ready) begin
                chk("pop_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("pop_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HADDR = '0; HSIZE = HSIZE_WORD;
    endtask

    task automatic bus_addr(input logic wr, input logic [31:0] addr, input logic [2:0] size);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HADDR = addr; HSIZE = size;
    endtask

    // Entered and left just after a rising edge; one address phase plus its data phase
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic [1:0] resp1, output logic [1:0] resp, output int waits);
        bus_addr(wr, addr, size);
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA   = wdata;
        dp_flush = wr && (addr[3:2] == OFF_CTRL) && wdata[CTRL_FLUSH];
        waits = 0; rdata = '0; resp1 = '0; resp = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge HCLK);
            if (i == 0) resp1 = out_HRESP;
            rdata = out_HRDATA;
            resp  = out_HRESP;
            if (out_HREADY) break;
            waits++;
            @(posedge HCLK); #1;
        end
        if (!out_HREADY) chk("xfer_bound", 32'(out_HREADY), 32'd1);
        @(posedge HCLK); #1;
        dp_flush = 1'b0;
    endtask

    task automatic wr_data(input logic [31:0] d);
        logic [31:0] rd; logic [1:0] r1, r; int w;
        exp_q.push_back(d);
        xfer(1'b1, 32'h0, HSIZE_WORD, d, rd, r1, r, w);
        chk("wr_resp", 32'(r), 32'(HRESP_OKAY));
        chk("wr_waits", 32'(w), 32'd0);
    endtask

    task automatic reg_wr(input logic [31:0] addr, input logic [31:0] d);
        logic [31:0] rd; logic [1:0] r1, r; int w;
        xfer(1'b1, addr, HSIZE_WORD, d, rd, r1, r, w);
        chk("reg_wr_resp", 32'(r), 32'(HRESP_OKAY));
        chk("reg_wr_waits", 32'(w), 32'd0);
    endtask

    task automatic reg_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd; logic [1:0] r1, r; int w;
        xfer(1'b0, addr, HSIZE_WORD, 32'h0, rd, r1, r, w);
        chk(tag, rd, exp);
        chk("reg_rd_resp", 32'(r), 32'(HRESP_OKAY));
    endtask

    task automatic err_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [2:0] size);
        logic [31:0] rd; logic [1:0] r1, r; int w;
        xfer(wr, addr, size, 32'hdead_beef, rd, r1, r, w);
        chk({tag, "_resp1"}, 32'(r1), 32'(HRESP_ERROR));
        chk({tag, "_resp2"}, 32'(r), 32'(HRESP_ERROR));
        chk({tag, "_waits"}, 32'(w), 32'd1);
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge HCLK);
            if (!m_valid) break;
            @(posedge HCLK); #1;
        end
        m_ready = 1'b0;
        @(posedge HCLK); #1;
        chk("drain_fill", 32'(fill_level), 32'd0);
        chk("drain_q", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        HRESET = 1'b1; m_ready = 1'b0; HWDATA = '0; HBURST = '0;
        bus_idle();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_hready", 32'(out_HREADY), 32'd1);
        chk("rst_hresp", 32'(out_HRESP), 32'(HRESP_OKAY));
        chk("rst_hrdata", out_HRDATA, 32'h0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        // Three zero-wait writes, then STATUS
        wr_data(32'h11); wr_data(32'h22); wr_data(32'h33);
        chk("t1_fill", 32'(fill_level), 32'd3);
        chk("t1_head", m_data, 32'h11);
        chk("t1_mvalid", 32'(m_valid), 32'd1);
        reg_rd("t1_status", 32'h4, 32'h0000_0003);
        drain();

        // Fill to DEPTH, then a 17th write stalls until one pop
        for (int i = 1; i <= DEPTH; i++) wr_data(32'h100 + 32'(i));
        reg_rd("t2_status_full", 32'h4, 32'h0002_0010);
        exp_q.push_back(32'h111);
        bus_addr(1'b1, 32'h0, HSIZE_WORD);
        @(posedge HCLK); #1;
        bus_idle(); HWDATA = 32'h111;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK); chk("t2_stall", 32'(out_HREADY), 32'd0);
            @(posedge HCLK); #1;
        end
        m_ready = 1'b1;
        @(negedge HCLK);
        chk("t2_no_comb_ready", 32'(out_HREADY), 32'd0);
        chk("t2_pop_head", m_data, 32'h101);
        @(posedge HCLK); #1;
        m_ready = 1'b0;
        @(negedge HCLK);
        chk("t2_release", 32'(out_HREADY), 32'd1);
        chk("t2_release_resp", 32'(out_HRESP), 32'(HRESP_OKAY));
        @(posedge HCLK); #1;
        chk("t2_fill", 32'(fill_level), 32'd16);

        // Error responses and the sticky flag
        err_xfer("t3_byte_wr", 1'b1, 32'h0, 3'b000);
        chk("t3_no_push", 32'(fill_level), 32'd16);
        err_xfer("t3_rsvd_rd", 1'b0, 32'hC, HSIZE_WORD);
        reg_rd("t3_status_err", 32'h4, 32'h0006_0010);
        reg_wr(32'h8, 32'h2);
        reg_rd("t3_status_clr", 32'h4, 32'h0002_0010);

        // Flush, reload, flush again with the consumer ready
        reg_wr(32'h8, 32'h1);
        chk("t4_flush0_fill", 32'(fill_level), 32'd0);
        for (int i = 1; i <= 5; i++) wr_data(32'h200 + 32'(i));
        chk("t4_loaded", 32'(fill_level), 32'd5);
        m_ready = 1'b1;
        reg_wr(32'h8, 32'h1);
        chk("t4_fill", 32'(fill_level), 32'd0);
        chk("t4_mvalid", 32'(m_valid), 32'd0);
        wr_data(32'h301); wr_data(32'h302);
        @(posedge HCLK); #1;
        m_ready = 1'b0;
        chk("t4_post_fill", 32'(fill_level), 32'd0);
        chk("t4_post_q", 32'(exp_q.size()), 32'd0);

        // Pipelined DATA write then STATUS read, push and pop in the same cycle
        wr_data(32'h401); wr_data(32'h402);
        bus_addr(1'b1, 32'h0, HSIZE_WORD);
        @(posedge HCLK); #1;
        exp_q.push_back(32'h403);
        HWDATA = 32'h403; m_ready = 1'b1;
        bus_addr(1'b0, 32'h4, HSIZE_WORD);
        @(negedge HCLK);
        chk("t5_wr_ready", 32'(out_HREADY), 32'd1);
        chk("t5_wr_resp", 32'(out_HRESP), 32'(HRESP_OKAY));
        @(posedge HCLK); #1;
        bus_idle(); m_ready = 1'b0;
        @(negedge HCLK);
        chk("t5_rd_ready", 32'(out_HREADY), 32'd1);
        chk("t5_status", out_HRDATA, 32'h0000_0002);
        @(posedge HCLK); #1;
        chk("t5_fill", 32'(fill_level), 32'd2);
        drain();

        // Asynchronous reset during a full-FIFO wait state
        for (int i = 1; i <= DEPTH; i++) wr_data(32'h500 + 32'(i));
        bus_addr(1'b1, 32'h0, HSIZE_WORD);
        @(posedge HCLK); #1;
        bus_idle(); HWDATA = 32'h511;
        @(negedge HCLK);
        chk("t6_stall", 32'(out_HREADY), 32'd0);
        #2 HRESET = 1'b1;
        #1;
        chk("t6_rst_hready", 32'(out_HREADY), 32'd1);
        chk("t6_rst_hresp", 32'(out_HRESP), 32'(HRESP_OKAY));
        chk("t6_rst_mvalid", 32'(m_valid), 32'd0);
        chk("t6_rst_fill", 32'(fill_level), 32'd0);
        exp_q.delete();
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        wr_data(32'h600);
        chk("t6_fill", 32'(fill_level), 32'd1);
        chk("t6_head", m_data, 32'h600);
        reg_rd("t6_status", 32'h4, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
